// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - state encoding, key indices and paging helper for alu_seq_fpga
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_PAGE  = 1;
    localparam int KEY_CHAIN = 2;
    localparam int KEY_ABORT = 3;

    // Display pages needed to show a data_w-bit word, num_digits nibbles per page
    function automatic int num_pages(input int data_w, input int num_digits);
        return (data_w + 4 * num_digits - 1) / (4 * num_digits);
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types: ALU opcode and machine word
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU driven by alu_seq_fpga; overflow covers add, sub and signed left shift
module alu
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  aluop_t            op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              negative,
    output logic              overflow
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]          sh;
    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic [DATA_W-1:0]        sll_r;
    logic signed [DATA_W-1:0] sll_back;

    assign sh    = b[SH_W-1:0];
    assign sum   = a + b;
    assign diff  = a - b;
    assign sll_r = a << sh;

    // Operation select; a left shift overflows when shifting back arithmetically loses information
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        sll_back = $signed(sll_r) >>> sh;
        case (op)
            ALU_SLL: begin
                result   = sll_r;
                overflow = (sll_back != $signed(a));
            end
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = $unsigned($signed(a) >>> sh);
            ALU_ADD: begin
                result   = sum;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[DATA_W-1];

endmodule

// File: rtl/key_press_detect.sv
// rtl/key_press_detect.sv - 2-flop synchroniser plus falling-edge press pulse per active-low key
module key_press_detect #(
    parameter int NUM_KEYS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] press
);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] prev;

    // Synchronise the raw buttons and keep one cycle of history; reset to "released"
    // so that coming out of reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A press is the synchronised level going 1 -> 0; a held key gives one pulse only.
    assign press = prev & ~sync2;

endmodule

// File: rtl/alu_seq_fpga.sv
// rtl/alu_seq_fpga.sv - key-driven operand/op capture around an external ALU with paged hex display (option: ALU_SEQ_STICKY_FLAGS_EN)
module alu_seq_fpga
    import alu_seq_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 5,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [3:0]              KEY,
    input  logic [17:0]             SW,
    output logic [DATA_W-1:0]       alu_port_a,
    output logic [DATA_W-1:0]       alu_port_b,
    output aluop_t                  alu_op,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_zero,
    input  logic                    alu_negative,
    input  logic                    alu_overflow,
    output logic [4*NUM_DIGITS-1:0] hex_digits,
    output logic [2:0]              flags,
    output logic [2:0]              state_dbg,
    output logic                    busy
);

    localparam int PW    = 4 * NUM_DIGITS;
    localparam int NP    = num_pages(DATA_W, NUM_DIGITS);
    localparam int PAD_W = NP * PW;
    localparam int PG_W  = (NP > 1) ? $clog2(NP) : 1;
    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    state_t            state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    aluop_t            op_q;
    logic [DATA_W-1:0] result_q;
    logic [2:0]        flags_q;
    logic [PG_W-1:0]   page_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [17:0]       sw_q;
    logic [PW-1:0]     disp_hold;
    logic [PW-1:0]     disp;
    logic [PAD_W-1:0]  res_pad;
    logic [PAD_W-1:0]  sw_pad;
    logic [3:0]        press;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic              fresh_q;
`endif

    // Switch value widened to DATA_W; SW[17] chooses sign- over zero-extension of SW[16:0]
    function automatic logic [DATA_W-1:0] ext(input logic [17:0] s);
        return {{(DATA_W-17){s[17] & s[16]}}, s[16:0]};
    endfunction

    key_press_detect #(
        .NUM_KEYS (4)
    ) u_keys (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (KEY),
        .press (press)
    );

    // Zero-padded copies so any page slice past DATA_W reads as zero nibbles
    always_comb begin
        res_pad                = '0;
        res_pad[DATA_W-1:0]    = result_q;
        sw_pad                 = '0;
        sw_pad[DATA_W-1:0]     = ext(sw_q);
    end

    // Display source per state; EXEC replays whatever was on screen when it started
    always_comb begin
        disp = disp_hold;
        case (state)
            IDLE, WAIT_B: disp = sw_pad[PW-1:0];
            WAIT_OP: begin
                disp      = '0;
                disp[3:0] = sw_q[3:0];
            end
            SHOW:    disp = res_pad[int'(page_q)*PW +: PW];
            default: disp = disp_hold;
        endcase
    end

    // Sequencer: operand/op entry, timed execution, result display, chaining and abort
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= ALU_SLL;
            result_q  <= '0;
            flags_q   <= '0;
            page_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            sw_q      <= '0;
            disp_hold <= '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            fresh_q   <= 1'b0;
`endif
        end else begin
            sw_q <= SW;
            if (state != EXEC) begin
                disp_hold <= disp;
            end
            if (press[KEY_ABORT]) begin
                state    <= IDLE;
                a_q      <= '0;
                b_q      <= '0;
                op_q     <= ALU_SLL;
                result_q <= '0;
                flags_q  <= '0;
                page_q   <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press[KEY_ENTER]) begin
                            a_q   <= ext(sw_q);
                            state <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (press[KEY_ENTER]) begin
                            b_q   <= ext(sw_q);
                            state <= WAIT_OP;
                        end
                    end
                    WAIT_OP: begin
                        if (press[KEY_ENTER]) begin
                            op_q   <= aluop_t'(sw_q[3:0]);
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
                            state  <= EXEC;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                            fresh_q <= 1'b1;
`endif
                        end
                    end
                    EXEC: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(EXEC_CYCLES - 1)) begin
                            result_q <= alu_result;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                            flags_q  <= {alu_overflow | (~fresh_q & flags_q[2]),
                                         alu_negative, alu_zero};
`else
                            flags_q  <= {alu_overflow, alu_negative, alu_zero};
`endif
                            busy_q   <= 1'b0;
                            state    <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (press[KEY_PAGE]) begin
                            page_q <= (page_q == PG_W'(NP - 1)) ? '0 : page_q + 1'b1;
                        end
                        if (press[KEY_CHAIN]) begin
                            a_q    <= result_q;
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
                            state  <= EXEC;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                            fresh_q <= 1'b0;
`endif
                        end else if (press[KEY_ENTER]) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign alu_port_a = a_q;
    assign alu_port_b = b_q;
    assign alu_op     = op_q;
    assign hex_digits = disp;
    assign flags      = flags_q;
    assign state_dbg  = state;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_seq_fpga.sv
// tb/tb_alu_seq_fpga.sv - self-checking bench for alu_seq_fpga with the alu attached
module tb_alu_seq_fpga;
    import cpu_types_pkg::*;
    import alu_seq_pkg::*;

    localparam int DATA_W      = 32;
    localparam int NUM_DIGITS  = 5;
    localparam int EXEC_CYCLES = 2;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    localparam logic [2:0] CHAIN2_FLG = 3'b101;
`else
    localparam logic [2:0] CHAIN2_FLG = 3'b001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [17:0] sw;
    logic [31:0] port_a;
    logic [31:0] port_b;
    aluop_t      port_op;
    logic [31:0] alu_res;
    logic        alu_z;
    logic        alu_n;
    logic        alu_v;
    logic [19:0] hex;
    logic [2:0]  flg;
    logic [2:0]  st;
    logic        busy;

    always #5 clk = ~clk;

    alu_seq_fpga #(
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (NUM_DIGITS),
        .EXEC_CYCLES (EXEC_CYCLES)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .KEY          (key),
        .SW           (sw),
        .alu_port_a   (port_a),
        .alu_port_b   (port_b),
        .alu_op       (port_op),
        .alu_result   (alu_res),
        .alu_zero     (alu_z),
        .alu_negative (alu_n),
        .alu_overflow (alu_v),
        .hex_digits   (hex),
        .flags        (flg),
        .state_dbg    (st),
        .busy         (busy)
    );

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (port_a),
        .b        (port_b),
        .op       (port_op),
        .result   (alu_res),
        .zero     (alu_z),
        .negative (alu_n),
        .overflow (alu_v)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    typedef struct {
        logic [17:0] a_sw;
        logic [17:0] b_sw;
        aluop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t sb_e;
    int   exp_page = 0;
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;
    logic [2:0] prev_st = 3'd0;
    int   st_changes = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] page_slice(input logic [31:0] r, input int pg);
        logic [39:0] p;
        p = {8'h00, r};
        return p[pg*20 +: 20];
    endfunction

    // Scoreboard: each completed execution (busy falling into SHOW) pops one expectation
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (prev_busy && !busy) begin
            if (st == 3'd4 && !rst) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got result with hex 0x%0h expected none", hex);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_hex", 64'(hex), 64'(page_slice(sb_e.res, exp_page)));
                    check("sb_flags", 64'(flg), 64'(sb_e.flg));
                    check("sb_busy_cycles", 64'(busy_cnt), 64'(EXEC_CYCLES));
                end
            end
            busy_cnt = 0;
        end
        if (st != prev_st) st_changes++;
        prev_st   = st;
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        tick(2);
        key = ~mask;
        tick(hold);
        key = 4'hF;
        tick(6);
    endtask

    task automatic wait_show(input string name);
        for (int i = 0; i < 50; i++) begin
            if (st == 3'd4) break;
            tick(1);
        end
        check(name, 64'(st), 64'd4);
    endtask

    task automatic enter(input logic [17:0] a_sw, input logic [17:0] b_sw, input aluop_t op,
                         input logic [31:0] res, input logic [2:0] f);
        exp_t e;
        sw = a_sw;
        press(4'b0001, 4);
        sw = b_sw;
        press(4'b0001, 4);
        sw = {14'd0, op};
        e.res = res;
        e.flg = f;
        sb_q.push_back(e);
        press(4'b0001, 4);
        wait_show("enter_show");
    endtask

    task automatic chain(input logic [31:0] res, input logic [2:0] f);
        exp_t e;
        e.res = res;
        e.flg = f;
        sb_q.push_back(e);
        press(4'b0100, 4);
        wait_show("chain_show");
    endtask

    initial begin
        vecs[0] = '{18'h00005, 18'h00003, ALU_ADD, 32'h00000005, 32'h00000003, 32'h00000008, 3'b000};
        vecs[1] = '{18'h3FFFF, 18'h00001, ALU_SUB, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 3'b010};
        vecs[2] = '{18'h0F0F0, 18'h0FF00, ALU_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 3'b000};
        vecs[3] = '{18'h00007, 18'h00007, ALU_SUB, 32'h00000007, 32'h00000007, 32'h00000000, 3'b001};
        vecs[4] = '{18'h30000, 18'h00004, ALU_SRA, 32'hFFFF0000, 32'h00000004, 32'hFFFFF000, 3'b010};
        vecs[5] = '{18'h0000F, 18'h000F0, ALU_OR,  32'h0000000F, 32'h000000F0, 32'h000000FF, 3'b000};
        vecs[6] = '{18'h2FFFF, 18'h0FFFF, ALU_XOR, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 3'b001};

        rst = 1'b1;
        key = 4'hF;
        sw  = '0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rst_state", 64'(st), 64'd0);
        check("rst_hex", 64'(hex), 64'd0);
        check("rst_flags", 64'(flg), 64'd0);
        check("rst_port_a", 64'(port_a), 64'd0);
        check("rst_port_b", 64'(port_b), 64'd0);
        check("rst_op", 64'(port_op), 64'(ALU_SLL));
        check("rst_busy", 64'(busy), 64'd0);

        // Held KEY0 must produce exactly one transition
        sw = 18'h00012;
        tick(2);
        st_changes = 0;
        key = 4'hE;
        tick(100);
        key = 4'hF;
        tick(6);
        check("hold_transitions", 64'(st_changes), 64'd1);
        check("hold_state", 64'(st), 64'd1);
        check("hold_port_a", 64'(port_a), 64'h12);
        press(4'b1000, 4);
        check("hold_abort_state", 64'(st), 64'd0);

        for (int i = 0; i < 7; i++) begin
            enter(vecs[i].a_sw, vecs[i].b_sw, vecs[i].op, vecs[i].res, vecs[i].flg);
            check("vec_port_a", 64'(port_a), 64'(vecs[i].a));
            check("vec_port_b", 64'(port_b), 64'(vecs[i].b));
            check("vec_op", 64'(port_op), 64'(vecs[i].op));
            press(4'b0001, 4);
            check("vec_back_idle", 64'(st), 64'd0);
        end

        // Paging of the sign-extended subtract result, with wrap
        enter(18'h3FFFF, 18'h00001, ALU_SUB, 32'hFFFFFFFE, 3'b010);
        press(4'b0010, 4);
        exp_page = 1;
        check("page1_hex", 64'(hex), 64'h00FFF);
        press(4'b0010, 4);
        exp_page = 0;
        check("page_wrap_hex", 64'(hex), 64'hFFFFE);
        press(4'b0001, 4);
        press(4'b0010, 4);
        check("page_ignored_idle", 64'(st), 64'd0);

        // Chaining accumulates through A; B stays put
        enter(18'h00005, 18'h00003, ALU_ADD, 32'h00000008, 3'b000);
        chain(32'h0000000B, 3'b000);
        check("chain1_port_a", 64'(port_a), 64'h8);
        chain(32'h0000000E, 3'b000);
        check("chain2_port_a", 64'(port_a), 64'hB);
        check("chain_port_b", 64'(port_b), 64'h3);

        // KEY0 and KEY2 together in SHOW: chain wins
        chain(32'h00000011, 3'b000);
        sb_e.res = 32'h00000014;
        sb_e.flg = 3'b000;
        sb_q.push_back(sb_e);
        press(4'b0101, 4);
        wait_show("chain_over_enter");
        press(4'b0001, 4);

        // Overflow stickiness across chains
        enter(18'h08000, 18'h00010, ALU_SLL, 32'h80000000, 3'b110);
        chain(32'h00000000, 3'b101);
        chain(32'h00000000, CHAIN2_FLG);
        press(4'b1000, 4);
        check("abort_flags", 64'(flg), 64'd0);
        check("abort_state", 64'(st), 64'd0);
        check("abort_port_a", 64'(port_a), 64'd0);
        enter(18'h08000, 18'h00010, ALU_SLL, 32'h80000000, 3'b110);
        press(4'b0001, 4);
        enter(18'h00001, 18'h00001, ALU_ADD, 32'h00000002, 3'b000);
        press(4'b0001, 4);

        // KEY3 together with KEY0 in WAIT_B: abort, nothing loaded
        sw = 18'h00005;
        press(4'b0001, 4);
        check("wb_state", 64'(st), 64'd1);
        sw = 18'h00009;
        press(4'b1001, 4);
        check("abort_wb_state", 64'(st), 64'd0);
        check("abort_wb_a", 64'(port_a), 64'd0);
        check("abort_wb_b", 64'(port_b), 64'd0);
        check("abort_wb_op", 64'(port_op), 64'(ALU_SLL));
        check("abort_wb_flags", 64'(flg), 64'd0);

        // RST on the first EXEC cycle
        sw = 18'h00005;
        press(4'b0001, 4);
        sw = 18'h00003;
        press(4'b0001, 4);
        sw = {14'd0, ALU_ADD};
        tick(2);
        key = 4'hE;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check("rst_exec_entered", 64'(st), 64'd3);
        rst = 1'b1;
        key = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(6);
        check("rst_exec_state", 64'(st), 64'd0);
        check("rst_exec_flags", 64'(flg), 64'd0);
        check("rst_exec_busy", 64'(busy), 64'd0);
        check("rst_exec_port_a", 64'(port_a), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
